ad_ip_jesd204_tpl_adc_capture: RTL

- Capture and streaming stage that sits between the per-channel formatters of a JESD204 TPL ADC and the DMA/unpacker.
- Replaces the fixed "always valid, never backpressured" output with an armed, SOF-aligned capture and an optional fixed burst length.
- Adds a first-word-fall-through (FWFT) buffer with ready/valid backpressure, per-channel enable masking and sticky overflow reporting.

---
 rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv | 22 ++
 rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv | 81 ++++++++
 rtl/ad_ip_jesd204_tpl_adc_capture.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_capture_pkg.sv
// -----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_capture_pkg
//
// Shared definitions for the TPL ADC capture stage:
//   - capture_state_t : capture FSM state encoding (IDLE=0, ARMED=1, CAPTURE=2)
//   - lane_width()    : width of one channel's lane inside a DMA beat
// -----------------------------------------------------------------------------
package ad_ip_jesd204_tpl_adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } capture_state_t;

    // One channel occupies DATA_PATH_WIDTH consecutive samples in a beat.
    function automatic int unsigned lane_width(input int unsigned data_path_width,
                                               input int unsigned bits_per_sample);
        return data_path_width * bits_per_sample;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_capture_fifo.sv
// -----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_capture_fifo
//
// First-word-fall-through buffer of 2**DEPTH_LOG2 entries.
//
// Ports:
//   clk      in   clock
//   resetn   in   asynchronous active-low reset (empties the buffer)
//   wr_en    in   write request
//   wr_data  in   write data
//   rd_en    in   pop request (ignored while empty)
//   rd_data  out  head entry; zero while empty
//   rd_valid out  head entry is valid (buffer not empty)
//   full     out  all entries occupied
//   empty    out  no entries occupied
//
// A write into a full buffer is still accepted when a pop happens in the
// same cycle, because the head slot is freed at the same edge.
// -----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_capture_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [DEPTH_LOG2:0]   wr_ptr_reg;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rd_fire;
    logic wr_fire;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; pointer reset alone makes old contents
    // unreachable, and the output is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Head is read straight from storage so a write into an empty buffer
    // is visible on the very next cycle.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// -----------------------------------------------------------------------------
// ad_ip_jesd204_tpl_adc_capture
//
// Armed, SOF-aligned capture stage between the TPL ADC channel formatters and
// the DMA. A capture is armed by a pulse on arm, starts on the first valid
// SOF beat, and either runs for burst_len+1 beats (burst_mode=1) or until
// disarm (burst_mode=0). Captured beats pass through an FWFT buffer with
// ready/valid handshake; beats that find the buffer full are dropped and
// reported via a sticky overflow flag.
//
// Ports:
//   clk           in   link clock
//   resetn        in   asynchronous active-low reset
//   in_valid      in   formatted beat valid
//   in_sof        in   beat starts a frame-aligned multiframe
//   in_data       in   formatted samples, channel i at lane i
//   ch_enable     in   per-channel enable, sampled on arm
//   arm           in   pulse: start a capture (only in IDLE)
//   disarm        in   pulse: stop a capture
//   burst_mode    in   1 = fixed-length burst, 0 = continuous; sampled on arm
//   burst_len     in   beats per burst minus one; sampled on arm
//   overflow_clr  in   clears the sticky overflow flag
//   adc_valid     out  output beat valid
//   adc_ready     in   downstream ready
//   adc_data      out  output beat
//   adc_enable    out  channel enables latched at arm
//   busy          out  capture armed or running
//   done          out  one-cycle pulse after a burst completes
//   overflow      out  sticky: a beat was dropped on a full buffer
// -----------------------------------------------------------------------------
module ad_ip_jesd204_tpl_adc_capture
    import ad_ip_jesd204_tpl_adc_capture_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_PATH_WIDTH = 1,
    parameter int BITS_PER_SAMPLE = 16,
    parameter int DMA_DATA_WIDTH  = NUM_CHANNELS * DATA_PATH_WIDTH * BITS_PER_SAMPLE,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int BURST_LEN_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DMA_DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_CHANNELS-1:0]    ch_enable,
    input  logic                       arm,
    input  logic                       disarm,
    input  logic                       burst_mode,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    input  logic                       overflow_clr,
    output logic                       adc_valid,
    input  logic                       adc_ready,
    output logic [DMA_DATA_WIDTH-1:0]  adc_data,
    output logic [NUM_CHANNELS-1:0]    adc_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow
);

    localparam int LANE_W = lane_width(DATA_PATH_WIDTH, BITS_PER_SAMPLE);
    localparam logic [BURST_LEN_WIDTH-1:0] CNT_ONE = 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    capture_state_t              state_reg,      state_next;
    logic [NUM_CHANNELS-1:0]     adc_enable_reg, adc_enable_next;
    logic [BURST_LEN_WIDTH-1:0]  burst_len_reg,  burst_len_next;
    logic                        burst_mode_reg, burst_mode_next;
    logic [BURST_LEN_WIDTH-1:0]  beat_cnt_reg,   beat_cnt_next;
    logic                        done_reg,       done_next;
    logic                        overflow_reg,   overflow_next;

    // Beat offered to the buffer this cycle (accepted or dropped)
    logic                        offer;
    logic [DMA_DATA_WIDTH-1:0]   masked_data;

    logic                        fifo_valid;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        drop;

    // ------------------------------------------------------------------
    // Channel masking: uses the enables latched at arm, so changes on
    // ch_enable during a capture have no effect.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane_mask
        assign masked_data[gi*LANE_W +: LANE_W] =
            adc_enable_reg[gi] ? in_data[gi*LANE_W +: LANE_W] : '0;
    end

    // ------------------------------------------------------------------
    // Capture FSM, next-state and beat accounting
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        adc_enable_next = adc_enable_reg;
        burst_len_next  = burst_len_reg;
        burst_mode_next = burst_mode_reg;
        beat_cnt_next   = beat_cnt_reg;
        done_next       = 1'b0;
        offer           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // arm takes priority over a coincident disarm here
                if (arm) begin
                    state_next      = ST_ARMED;
                    adc_enable_next = ch_enable;
                    burst_len_next  = burst_len;
                    burst_mode_next = burst_mode;
                    beat_cnt_next   = '0;
                end
            end

            ST_ARMED: begin
                if (disarm) begin
                    state_next = ST_IDLE;
                end else if (in_valid && in_sof) begin
                    // The SOF beat itself is the first captured beat and
                    // may also be the last one when burst_len is zero.
                    offer         = 1'b1;
                    beat_cnt_next = beat_cnt_reg + CNT_ONE;
                    if (burst_mode_reg && (beat_cnt_reg == burst_len_reg)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                // disarm wins over a beat in the same cycle
                if (disarm) begin
                    state_next = ST_IDLE;
                end else if (in_valid) begin
                    offer         = 1'b1;
                    beat_cnt_next = beat_cnt_reg + CNT_ONE;
                    if (burst_mode_reg && (beat_cnt_reg == burst_len_reg)) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Overflow: a drop is an offered beat that finds the buffer full with
    // no pop freeing a slot in the same cycle. A drop outranks a clear.
    // ------------------------------------------------------------------
    assign pop  = adc_ready && !fifo_empty;
    assign drop = offer && fifo_full && !pop;

    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (overflow_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            adc_enable_reg <= '0;
            burst_len_reg  <= '0;
            burst_mode_reg <= 1'b0;
            beat_cnt_reg   <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            adc_enable_reg <= adc_enable_next;
            burst_len_reg  <= burst_len_next;
            burst_mode_reg <= burst_mode_next;
            beat_cnt_reg   <= beat_cnt_next;
            done_reg       <= done_next;
            overflow_reg   <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    ad_ip_jesd204_tpl_adc_capture_fifo #(
        .DATA_WIDTH (DMA_DATA_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) i_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (offer),
        .wr_data  (masked_data),
        .rd_en    (pop),
        .rd_data  (adc_data),
        .rd_valid (fifo_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign adc_valid  = fifo_valid;
    assign adc_enable = adc_enable_reg;
    assign busy       = (state_reg == ST_ARMED) || (state_reg == ST_CAPTURE);
    assign done       = done_reg;
    assign overflow   = overflow_reg;

endmodule
